// File: rtl/periferico_pkg.sv
// Shared definitions for the periferico receiver: handshake FSM encoding and default sizing.
package periferico_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rxState_t;

  localparam int DEFAULT_W     = 16;
  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/periferico_fifo.sv
// Receive FIFO for periferico_receptor: first-word-fall-through, occupancy counter drives full/empty.
module periferico_fifo
  import periferico_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrEn,
  input  logic [W-1:0]             wrData,
  input  logic                     rdEn,
  output logic [W-1:0]             rdData,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doWrite;
  logic          doRead;

  assign doWrite = wrEn && !full;
  assign doRead  = rdEn && !empty;

  // Storage is deliberately left out of reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doRead) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doWrite, doRead})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdData = mem[rdPtr];
  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);

endmodule

// File: rtl/periferico_receptor.sv
// Four-phase handshake receiver feeding a FIFO. Define SEND_SYNC_EN to pass send through a
// two-flop synchronizer; without it send is used directly.
module periferico_receptor
  import periferico_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             dado,
  input  logic                     send,
  output logic                     ack,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  rxState_t state;
  logic     sendS;
  logic     wrEn;

`ifdef SEND_SYNC_EN
  logic sendMeta;
  logic sendSync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sendMeta <= 1'b0;
      sendSync <= 1'b0;
    end else begin
      sendMeta <= send;
      sendSync <= sendMeta;
    end
  end

  assign sendS = sendSync;
`else
  assign sendS = send;
`endif

  // Writing only from IDLE guarantees one FIFO entry per send pulse, however long it lasts.
  assign wrEn = (state == IDLE) && sendS && !full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wrEn) begin
            state <= ACK;
            ack   <= 1'b1;
          end
        end
        ACK: begin
          if (!sendS) begin
            state <= IDLE;
            ack   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  periferico_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wrEn),
    .wrData (dado),
    .rdEn   (rd_en),
    .rdData (rd_data),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

endmodule

// File: tb/tb_periferico_receptor.sv
// Directed-plus-random bench for periferico_receptor; a queue model tracks what the FIFO must hold.
module tb_periferico_receptor;

  localparam int W     = 16;
  localparam int DEPTH = 4;
`ifdef SEND_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] dado = '0;
  logic         send = 1'b0;
  logic         ack;
  logic         rd_en = 1'b0;
  logic [W-1:0] rd_data;
  logic         empty;
  logic         full;
  logic [2:0]   count;

  int compareCnt = 0;
  int failCnt    = 0;

  logic [W-1:0] model[$];

  periferico_receptor #(.W(W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .dado    (dado),
    .send    (send),
    .ack     (ack),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Occupancy flags and head word all follow from the model queue.
  task automatic checkModel(input string tag);
    checkOutput({tag, "_count"}, 32'(count), 32'(model.size()));
    checkOutput({tag, "_empty"}, 32'(empty), 32'(model.size() == 0));
    checkOutput({tag, "_full"},  32'(full),  32'(model.size() == DEPTH));
    if (model.size() > 0) begin
      checkOutput({tag, "_head"}, 32'(rd_data), 32'(model[0]));
    end
  endtask

  task automatic waitAck(input logic target, input int expEdges, input string tag);
    int n = 0;
    while (ack !== target && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_ack"}, 32'(ack), 32'(target));
    checkOutput({tag, "_lat"}, 32'(n), 32'(expEdges));
  endtask

  task automatic applyStimulus(input logic [W-1:0] word, input string tag);
    dado = word;
    send = 1'b1;
    waitAck(1'b1, LAT, {tag, "_rise"});
    model.push_back(word);
    checkModel(tag);
    send = 1'b0;
    waitAck(1'b0, LAT, {tag, "_fall"});
  endtask

  task automatic popWord(input string tag, output logic [W-1:0] got);
    got = rd_data;
    if (model.size() > 0) begin
      checkOutput({tag, "_rd"}, 32'(rd_data), 32'(model[0]));
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (model.size() > 0) begin
      void'(model.pop_front());
    end
    checkModel(tag);
  endtask

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] word;
    int readIdx;

    $display("[TB] start, send latency %0d", LAT);
    repeat (2) tick();
    checkOutput("rstAck", 32'(ack), 32'd0);
    checkModel("rst");
    @(negedge clk);
    rst = 1'b1;

    // Single handshake with the reference word.
    applyStimulus(16'hA5A5, "a5");
    checkOutput("a5Data", 32'(rd_data), 32'h0000A5A5);
    popWord("a5Pop", got);

    // Fill to full, then a fifth request must wait for space.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(W'(i), "fill");
    end
    checkOutput("fillFull", 32'(full), 32'd1);
    dado = 16'h0005;
    send = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("bpAck", 32'(ack), 32'd0);
    end
    checkModel("bpHold");
    popWord("bpPop", got);
    checkOutput("bpFirst", 32'(got), 32'h0001);
    waitAck(1'b1, 1, "bpResume");
    model.push_back(16'h0005);
    checkModel("bpStored");
    send = 1'b0;
    waitAck(1'b0, LAT, "bpFall");
    while (model.size() > 0) begin
      popWord("bpDrain", got);
    end

    // Sixteen words with interleaved reads so both pointers wrap several times.
    readIdx = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(W'(i), "wrap");
      if ((i % 3) == 2 || model.size() == DEPTH) begin
        popWord("wrapPop", got);
        checkOutput("wrapOrder", 32'(got), 32'(readIdx));
        readIdx++;
      end
    end
    while (model.size() > 0) begin
      popWord("wrapPop", got);
      checkOutput("wrapOrder", 32'(got), 32'(readIdx));
      readIdx++;
    end
    checkOutput("wrapTotal", 32'(readIdx), 32'd16);
    checkOutput("wrapEmpty", 32'(empty), 32'd1);

    // Write and read landing on the same edge.
    applyStimulus(W'($urandom), "simA");
    applyStimulus(W'($urandom), "simB");
    word = W'($urandom);
    dado = word;
    send = 1'b1;
    for (int e = 0; e < LAT; e++) begin
      rd_en = (e == LAT - 1);
      if (e == LAT - 1) begin
        checkOutput("simHead", 32'(rd_data), 32'(model[0]));
      end
      tick();
    end
    rd_en = 1'b0;
    void'(model.pop_front());
    model.push_back(word);
    checkOutput("simAck", 32'(ack), 32'd1);
    checkModel("simBoth");
    send = 1'b0;
    waitAck(1'b0, LAT, "simFall");
    popWord("simOld", got);
    popWord("simNew", got);
    checkOutput("simNewWord", 32'(got), 32'(word));

    // Reset in the middle of a handshake with three words stored.
    applyStimulus(W'($urandom), "rsA");
    applyStimulus(W'($urandom), "rsB");
    word = W'($urandom);
    dado = word;
    send = 1'b1;
    waitAck(1'b1, LAT, "rsRise");
    model.push_back(word);
    checkModel("rsThree");
    #2;
    rst = 1'b0;
    #1;
    model.delete();
    checkOutput("rsAck", 32'(ack), 32'd0);
    checkModel("rsAsync");
    tick();
    @(negedge clk);
    rst = 1'b1;
    waitAck(1'b1, LAT, "rsRelease");
    model.push_back(word);
    checkModel("rsNew");
    send = 1'b0;
    waitAck(1'b0, LAT, "rsFall");
    popWord("rsPop", got);

    // A long send pulse still yields a single write.
    word = W'($urandom);
    dado = word;
    send = 1'b1;
    waitAck(1'b1, LAT, "longRise");
    model.push_back(word);
    for (int i = 0; i < 50 - LAT; i++) begin
      tick();
      if ((i % 10) == 9) begin
        checkModel("longHold");
      end
    end
    send = 1'b0;
    waitAck(1'b0, LAT, "longFall");
    checkModel("longDone");
    popWord("longPop", got);

    // Reads on an empty FIFO are ignored.
    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    checkModel("emptyRead");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
    $finish;
  end

endmodule
